parking_slot_dispatcher: RTL and testbench

Request front-end sitting directly upstream of the elevator controller in the parking lot. It captures the one-cycle `in_mode`/`out_mode` pulses together with `license_plate` into a small queue. For each request it picks a target slot: a free slot for entries, the slot holding the plate for exits. It then issues exactly one command at a time to the elevator over a valid/ready handshake and holds further commands until that command reports completion.

---
 rtl/parking_pkg.sv | 46 ++++
 rtl/request_fifo.sv | 53 +++++
 rtl/parking_slot_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_parking_slot_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot request front-end: plate field
// layout, reject codes, dispatcher states and slot allocation order.
package parking_pkg;

  // Plate fields
  localparam logic [3:0] HANDI   = 4'b1001;
  localparam logic [3:0] HYBRID  = 4'b1000;
  localparam int         SUV_BIT = 11;

  // Lot geometry: slot id = 2*(floor-1) + place, place 0 = left, 1 = right
  localparam int NUM_FLOORS = 7;
  localparam int NUM_SLOTS  = 2 * NUM_FLOORS;

  // Reject codes
  localparam logic [2:0] REJ_NONE     = 3'd0;
  localparam logic [2:0] REJ_FULL     = 3'd3;
  localparam logic [2:0] REJ_NOTFOUND = 3'd4;
  localparam logic [2:0] REJ_DUP      = 3'd5;
  localparam logic [2:0] REJ_BADPLATE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_BUSY   = 2'd3
  } disp_state_t;

  // Allocation priority, expressed as slot ids. 1L (0) and 2L (2) never appear.
  localparam int SUV_N   = 7;
  localparam int SEDAN_N = 5;
  // 1R, 3L, 3R, 5L, 5R, 7L, 7R
  localparam logic [3:0] SUV_ORDER [SUV_N] =
    '{4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13};
  // 2R, 4L, 4R, 6L, 6R
  localparam logic [3:0] SEDAN_ORDER [SEDAN_N] =
    '{4'd3, 4'd6, 4'd7, 4'd10, 4'd11};

  function automatic logic [2:0] slot_floor(input logic [3:0] slot);
    return slot[3:1] + 3'd1;
  endfunction

  function automatic logic slot_place(input logic [3:0] slot);
    return slot[0];
  endfunction

endpackage

// File: rtl/request_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending {dir, plate}
// requests. Push and pop in the same cycle are both honoured, even when full.
module request_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; no reset needed since count gates what is visible
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parking_slot_dispatcher.sv
// Front-end for the elevator controller: queues entry/exit requests, picks
// a target slot and hands exactly one command at a time to the elevator.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no command outstanding; pops the queue when non-empty
// ST_LOOKUP | evaluate popped request against the occupancy map
// ST_ISSUE  | cmd_valid held with stable cmd_* until cmd_ready
// ST_BUSY   | command accepted, waiting for cmd_done
module parking_slot_dispatcher
  import parking_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int PLATE_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PLATE_W-1:0]           license_plate,
  input  logic                         in_mode,
  input  logic                         out_mode,
  input  logic                         leakage,
  input  logic [2:0]                   leakage_floor,
  input  logic [NUM_SLOTS*PLATE_W-1:0] slot_plates,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic                         cmd_dir,
  output logic [PLATE_W-1:0]           cmd_plate,
  output logic [2:0]                   cmd_floor,
  output logic                         cmd_place,
  input  logic                         cmd_done,
  output logic                         rej_valid,
  output logic [2:0]                   rej_code,
  output logic                         q_drop,
  output logic [2:0]                   q_count,
  output logic                         busy
);

  disp_state_t state;

  logic [PLATE_W:0]         fifo_din;
  logic [PLATE_W:0]         fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(QDEPTH):0]  fifo_count;
  logic                     push;
  logic                     pop;
  logic                     drop_now;

  logic                     req_dir;
  logic [PLATE_W-1:0]       req_plate;

  logic [PLATE_W-1:0]       occ [NUM_SLOTS];

  logic                     alloc_found;
  logic [3:0]               alloc_slot;
  logic                     dup_hit;
  logic                     exit_found;
  logic [3:0]               exit_slot;
  logic                     lk_ok;
  logic [2:0]               lk_code;
  logic [3:0]               lk_slot;

  // Simultaneous in/out keeps only the exit request
  assign push     = in_mode | out_mode;
  assign fifo_din = {out_mode, license_plate};
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign drop_now = (in_mode & out_mode) | (push & fifo_full & !pop);
  assign q_count  = 3'(fifo_count);

  request_fifo #(
    .WIDTH (PLATE_W + 1),
    .DEPTH (QDEPTH)
  ) u_request_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Unpack the occupancy map: each floor carries left in the upper half
  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_occ
    assign occ[2*g]   = slot_plates[2*PLATE_W*g + PLATE_W +: PLATE_W];
    assign occ[2*g+1] = slot_plates[2*PLATE_W*g +: PLATE_W];
  end

  // Slot allocation, duplicate detection and exit search
  always_comb begin
    alloc_found = 1'b0;
    alloc_slot  = '0;
    if (req_plate[SUV_BIT]) begin
      for (int i = 0; i < SUV_N; i++) begin
        if (!alloc_found && occ[SUV_ORDER[i]] == '0 &&
            !(leakage && slot_floor(SUV_ORDER[i]) == leakage_floor)) begin
          alloc_found = 1'b1;
          alloc_slot  = SUV_ORDER[i];
        end
      end
    end else begin
      for (int i = 0; i < SEDAN_N; i++) begin
        if (!alloc_found && occ[SEDAN_ORDER[i]] == '0 &&
            !(leakage && slot_floor(SEDAN_ORDER[i]) == leakage_floor)) begin
          alloc_found = 1'b1;
          alloc_slot  = SEDAN_ORDER[i];
        end
      end
    end

    // Scan order is floor 1..7, left before right; first hit wins
    dup_hit    = 1'b0;
    exit_found = 1'b0;
    exit_slot  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (occ[i] == req_plate) begin
        dup_hit = 1'b1;
        if (!exit_found) begin
          exit_found = 1'b1;
          exit_slot  = 4'(i);
        end
      end
    end
  end

  // Request verdict with reject reasons in priority order
  always_comb begin
    lk_ok   = 1'b0;
    lk_code = REJ_NONE;
    lk_slot = '0;
    if (req_plate == '0) begin
      lk_code = REJ_BADPLATE;
    end else if (!req_dir) begin
      if (dup_hit) begin
        lk_code = REJ_DUP;
      end else if (!alloc_found) begin
        lk_code = REJ_FULL;
      end else begin
        lk_ok   = 1'b1;
        lk_slot = alloc_slot;
      end
    end else if (!exit_found) begin
      lk_code = REJ_NOTFOUND;
    end else begin
      lk_ok   = 1'b1;
      lk_slot = exit_slot;
    end
  end

  // Dispatcher FSM with registered command, reject and drop outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_dir   <= 1'b0;
      req_plate <= '0;
      cmd_valid <= 1'b0;
      cmd_dir   <= 1'b0;
      cmd_plate <= '0;
      cmd_floor <= '0;
      cmd_place <= 1'b0;
      rej_valid <= 1'b0;
      rej_code  <= REJ_NONE;
      q_drop    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rej_valid <= 1'b0;
      q_drop    <= drop_now;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            req_dir   <= fifo_dout[PLATE_W];
            req_plate <= fifo_dout[PLATE_W-1:0];
            busy      <= 1'b1;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lk_ok) begin
            cmd_valid <= 1'b1;
            cmd_dir   <= req_dir;
            cmd_plate <= req_plate;
            cmd_floor <= slot_floor(lk_slot);
            cmd_place <= slot_place(lk_slot);
            state     <= ST_ISSUE;
          end else begin
            rej_valid <= 1'b1;
            rej_code  <= lk_code;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cmd_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_slot_dispatcher.sv
// Directed bench for parking_slot_dispatcher with hand-computed expectations.
module tb_parking_slot_dispatcher;

  logic         clock;
  logic         reset;
  logic [15:0]  license_plate;
  logic         in_mode;
  logic         out_mode;
  logic         leakage;
  logic [2:0]   leakage_floor;
  logic [223:0] slot_plates;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [15:0]  cmd_plate;
  logic [2:0]   cmd_floor;
  logic         cmd_place;
  logic         cmd_done;
  logic         rej_valid;
  logic [2:0]   rej_code;
  logic         q_drop;
  logic [2:0]   q_count;
  logic         busy;

  // lot[2*(floor-1)+place], place 0 = left, 1 = right
  logic [15:0]  lot [14];

  int n_vec = 0;
  int n_err = 0;

  parking_slot_dispatcher #(.QDEPTH(4), .PLATE_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .license_plate (license_plate),
    .in_mode       (in_mode),
    .out_mode      (out_mode),
    .leakage       (leakage),
    .leakage_floor (leakage_floor),
    .slot_plates   (slot_plates),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_plate     (cmd_plate),
    .cmd_floor     (cmd_floor),
    .cmd_place     (cmd_place),
    .cmd_done      (cmd_done),
    .rej_valid     (rej_valid),
    .rej_code      (rej_code),
    .q_drop        (q_drop),
    .q_count       (q_count),
    .busy          (busy)
  );

  for (genvar g = 0; g < 7; g++) begin : g_map
    assign slot_plates[32*g+16 +: 16] = lot[2*g];
    assign slot_plates[32*g    +: 16] = lot[2*g+1];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_lot();
    for (int i = 0; i < 14; i++) lot[i] = 16'h0;
  endtask

  task automatic pulse(input logic in_p, input logic out_p, input logic [15:0] plate);
    in_mode       = in_p;
    out_mode      = out_p;
    license_plate = plate;
    tick();
    in_mode  = 1'b0;
    out_mode = 1'b0;
  endtask

  // Pulse a request into an idle, empty dispatcher and move to the cycle after E2
  task automatic request(input logic in_p, input logic out_p, input logic [15:0] plate);
    pulse(in_p, out_p, plate);
    tick();
    tick();
  endtask

  task automatic complete();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b1;
    tick();
    cmd_done  = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic dir, input logic [15:0] plate,
                         input logic [2:0] floor, input logic place);
    chk({tag, ".valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, ".dir"},   32'(cmd_dir),   32'(dir));
    chk({tag, ".plate"}, 32'(cmd_plate), 32'(plate));
    chk({tag, ".floor"}, 32'(cmd_floor), 32'(floor));
    chk({tag, ".place"}, 32'(cmd_place), 32'(place));
  endtask

  task automatic chk_rej(input string tag, input logic [2:0] code);
    chk({tag, ".rej_valid"}, 32'(rej_valid), 32'd1);
    chk({tag, ".rej_code"},  32'(rej_code),  32'(code));
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    in_mode       = 1'b0;
    out_mode      = 1'b0;
    license_plate = 16'h0;
    leakage       = 1'b0;
    leakage_floor = 3'd0;
    cmd_ready     = 1'b0;
    cmd_done      = 1'b0;
    clear_lot();
    #12;
    chk("rst.cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst.cmd_plate", 32'(cmd_plate), 32'd0);
    chk("rst.cmd_floor", 32'(cmd_floor), 32'd0);
    chk("rst.rej_valid", 32'(rej_valid), 32'd0);
    chk("rst.q_drop",    32'(q_drop),    32'd0);
    chk("rst.q_count",   32'(q_count),   32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    reset = 1'b0;
    tick();

    // Basic SUV entry into empty lot, with a held-off handshake
    pulse(1'b1, 1'b0, 16'h0801);
    chk("t1.q_count_e0", 32'(q_count), 32'd1);
    tick();
    chk("t1.busy_e1",  32'(busy),      32'd1);
    chk("t1.valid_e1", 32'(cmd_valid), 32'd0);
    chk("t1.q_count_e1", 32'(q_count), 32'd0);
    tick();
    chk_cmd("t1.cmd", 1'b0, 16'h0801, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cmd("t1.hold", 1'b0, 16'h0801, 3'd1, 1'b1);
      chk("t1.hold.busy", 32'(busy), 32'd1);
    end
    // done in the accepting cycle must be ignored
    cmd_ready = 1'b1;
    cmd_done  = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    chk("t1.acc.valid", 32'(cmd_valid), 32'd0);
    chk("t1.acc.busy",  32'(busy),      32'd1);
    tick();
    tick();
    chk("t1.wait.busy", 32'(busy), 32'd1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t1.done.busy", 32'(busy), 32'd0);

    // Leak on floor 3 pushes an SUV from 3R to 5L
    lot[1] = 16'h0801;
    lot[4] = 16'h0900;
    leakage       = 1'b1;
    leakage_floor = 3'd3;
    request(1'b1, 1'b0, 16'h0855);
    chk_cmd("t2.leak", 1'b0, 16'h0855, 3'd5, 1'b0);
    complete();
    leakage = 1'b0;
    request(1'b1, 1'b0, 16'h0855);
    chk_cmd("t2.noleak", 1'b0, 16'h0855, 3'd3, 1'b1);
    complete();

    // Rejections and exits with all sedan slots taken
    clear_lot();
    lot[3]  = 16'h0101;
    lot[6]  = 16'h0102;
    lot[7]  = 16'h0103;
    lot[10] = 16'h0104;
    lot[11] = 16'h0105;
    request(1'b1, 1'b0, 16'h0402);
    chk_rej("t3.full", 3'd3);
    tick();
    chk("t3.full.pulse", 32'(rej_valid), 32'd0);
    chk("t3.full.novalid", 32'(cmd_valid), 32'd0);
    request(1'b0, 1'b1, 16'h1234);
    chk_rej("t3.notfound", 3'd4);
    request(1'b1, 1'b0, 16'h0000);
    chk_rej("t3.badplate", 3'd6);
    request(1'b1, 1'b0, 16'h0103);
    chk_rej("t3.dup", 3'd5);
    lot[0] = 16'h0999;
    request(1'b1, 1'b0, 16'h0999);
    chk_rej("t3.dup1l", 3'd5);
    request(1'b1, 1'b0, 16'h9000);
    chk_rej("t3.handi_sedan", 3'd3);
    request(1'b1, 1'b0, 16'h9801);
    chk_cmd("t3.handi_suv", 1'b0, 16'h9801, 3'd1, 1'b1);
    complete();
    leakage       = 1'b1;
    leakage_floor = 3'd4;
    request(1'b0, 1'b1, 16'h0102);
    chk_cmd("t3.exit_leak", 1'b1, 16'h0102, 3'd4, 1'b0);
    complete();
    leakage = 1'b0;
    lot[2] = 16'h0105;
    request(1'b0, 1'b1, 16'h0105);
    chk_cmd("t3.exit_first", 1'b1, 16'h0105, 3'd2, 1'b0);
    complete();

    // Simultaneous in and out: only the exit survives
    clear_lot();
    lot[12] = 16'h0777;
    pulse(1'b1, 1'b1, 16'h0777);
    chk("t4.q_drop",  32'(q_drop),  32'd1);
    chk("t4.q_count", 32'(q_count), 32'd1);
    tick();
    chk("t4.q_drop_end", 32'(q_drop),  32'd0);
    chk("t4.q_count_e1", 32'(q_count), 32'd0);
    tick();
    chk_cmd("t4.cmd", 1'b1, 16'h0777, 3'd7, 1'b0);
    complete();
    tick();
    tick();
    tick();
    chk("t4.after.valid", 32'(cmd_valid), 32'd0);
    chk("t4.after.busy",  32'(busy),      32'd0);

    // Queue fills while BUSY, fifth request dropped, then drains in order
    clear_lot();
    request(1'b1, 1'b0, 16'h0801);
    chk_cmd("t5.first", 1'b0, 16'h0801, 3'd1, 1'b1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(1'b1, 1'b0, 16'h0811 + 16'(k));
      if (k < 4) begin
        chk("t5.fill.count", 32'(q_count), 32'(k + 1));
        chk("t5.fill.drop",  32'(q_drop),  32'd0);
      end else begin
        chk("t5.over.count", 32'(q_count), 32'd4);
        chk("t5.over.drop",  32'(q_drop),  32'd1);
      end
    end
    tick();
    chk("t5.drop_end", 32'(q_drop), 32'd0);
    chk("t5.busy",     32'(busy),   32'd1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t5.idle.busy",  32'(busy),    32'd0);
    chk("t5.idle.count", 32'(q_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t5.gap0.valid", 32'(cmd_valid), 32'd0);
      tick();
      chk("t5.gap1.valid", 32'(cmd_valid), 32'd0);
      chk("t5.gap1.count", 32'(q_count),   32'(3 - k));
      tick();
      chk_cmd("t5.drain", 1'b0, 16'h0811 + 16'(k), 3'd1, 1'b1);
      complete();
      chk("t5.drain.busy", 32'(busy), 32'd0);
    end

    // Reset during ISSUE abandons the command and the queue
    clear_lot();
    pulse(1'b1, 1'b0, 16'h0801);
    pulse(1'b1, 1'b0, 16'h0802);
    tick();
    chk("t6.pre.valid", 32'(cmd_valid), 32'd1);
    chk("t6.pre.count", 32'(q_count),   32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.rst.valid", 32'(cmd_valid), 32'd0);
    chk("t6.rst.count", 32'(q_count),   32'd0);
    chk("t6.rst.busy",  32'(busy),      32'd0);
    #2;
    reset    = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t6.done.busy",  32'(busy),      32'd0);
    chk("t6.done.valid", 32'(cmd_valid), 32'd0);
    tick();
    tick();
    chk("t6.quiet.valid", 32'(cmd_valid), 32'd0);
    chk("t6.quiet.rej",   32'(rej_valid), 32'd0);
    chk("t6.quiet.busy",  32'(busy),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
